mux8_rr_sched: RTL and testbench

Round-robin source scheduler that sits directly upstream of the 8-way `mux8` data multiplexer. It arbitrates eight per-channel request lines, drives the mux `sel` input, and captures the mux output into a registered valid/ready output stage. It acknowledges each served channel with a one-cycle `ack` pulse so the requester can advance its data word.

---
 rtl/mux8_sched_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 31 +++
 rtl/mux8_rr_sched.sv | 89 ++++++++
 tb/tb_mux8_rr_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_sched_pkg.sv
// Shared types and constants for the mux8 round-robin scheduler.
package mux8_sched_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic [N_CH-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority search: first unmasked request at or after i_ptr, wrapping mod 8.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    input  logic [N_CH-1:0]  i_mask,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    logic [N_CH-1:0]  w_elig;
    logic [SEL_W-1:0] w_cand;

    assign w_elig = i_req & ~i_mask;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (w_elig[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving mux8.sel and registering the mux output
// behind a valid/ready stage, with a one-cycle ack per served channel.
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_req,
    output logic [N_CH-1:0]   o_ack,
    output logic [SEL_W-1:0]  o_sel,
    input  logic [DATA_W-1:0] i_mux_out,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready
);

    state_t            r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_ptr;
    logic [N_CH-1:0]   r_ack;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic [SEL_W-1:0]  w_pick_ptr;
    logic [N_CH-1:0]   w_pick_mask;
    logic              w_found;
    logic [SEL_W-1:0]  w_grant;

    // In HOLD the search starts from the pointer value being committed this
    // edge, and skips the channel just served (its req may linger after ack).
    assign w_pick_ptr  = (r_state == HOLD) ? r_sel + SEL_W'(1) : r_ptr;
    assign w_pick_mask = (r_state == HOLD) ? onehot8(r_sel) : '0;

    rr_pick8 u_pick (
        .i_req   (i_req),
        .i_ptr   (w_pick_ptr),
        .i_mask  (w_pick_mask),
        .o_found (w_found),
        .o_idx   (w_grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_ack       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_grant;
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    r_out_data  <= i_mux_out;
                    r_out_valid <= 1'b1;
                    r_ack       <= onehot8(r_sel);
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_ptr       <= r_sel + SEL_W'(1);
                        r_out_valid <= 1'b0;
                        if (w_found) begin
                            r_sel   <= w_grant;
                            r_state <= SELECT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_sel       = r_sel;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed scenarios plus randomized traffic against
// a transaction-level reference model; the bench also models mux8 itself.
module tb_mux8_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [7:0] data [8];
    logic [7:0] mux_out;
    logic [7:0] ack;
    logic [2:0] sel;
    logic [7:0] out_data;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_phase;
    int         m_sel;
    int         m_ptr;
    logic [7:0] m_ack;
    logic [7:0] m_data;
    logic       m_valid;

    always #5 clk = ~clk;

    assign mux_out = data[sel];

    mux8_rr_sched #(.DATA_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .o_ack       (ack),
        .o_sel       (sel),
        .i_mux_out   (mux_out),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (ready)
    );

    function automatic int pick(input logic [7:0] r, input int start, input int excl);
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (start + k) % 8;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        int g;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_sel = 0; m_ptr = 0;
            m_ack = 8'h00; m_valid = 1'b0; m_data = 8'h00;
        end else if (m_phase == 0) begin
            m_ack = 8'h00;
            g = pick(req, m_ptr, -1);
            if (g >= 0) begin m_sel = g; m_phase = 1; end
        end else if (m_phase == 1) begin
            m_data       = data[m_sel];
            m_valid      = 1'b1;
            m_ack        = 8'h00;
            m_ack[m_sel] = 1'b1;
            m_phase      = 2;
        end else begin
            m_ack = 8'h00;
            if (ready) begin
                m_ptr   = (m_sel + 1) % 8;
                m_valid = 1'b0;
                g = pick(req, m_ptr, m_sel);
                if (g >= 0) begin m_sel = g; m_phase = 1; end
                else m_phase = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (sel !== 3'd0 || out_valid !== 1'b0 || ack !== 8'h00 || out_data !== 8'h00) begin
                bad++;
                $display("FAIL reset cyc%0d got sel=%0d vld=%b ack=%h data=%h want 0/0/00/00",
                         c, sel, out_valid, ack, out_data);
            end
        end
        rst = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_single();
        data[5] = 8'hA5; req = 8'h20; ready = 1'b1;
        tick();
        total++;
        if (sel !== 3'd5 || out_valid !== 1'b0) begin
            bad++; $display("FAIL single_sel got sel=%0d vld=%b want 5/0", sel, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack !== 8'h20) begin
            bad++;
            $display("FAIL single_out got vld=%b data=%h ack=%h want 1/a5/20", out_valid, out_data, ack);
        end
        req = 8'h00;
        tick();
        total++;
        if (out_valid !== 1'b0 || ack !== 8'h00) begin
            bad++; $display("FAIL single_done got vld=%b ack=%h want 0/00", out_valid, ack);
        end
        // ptr is now 6: channel 6 must beat channel 0
        data[6] = 8'h66; req = 8'h41;
        tick();
        total++;
        if (sel !== 3'd6) begin bad++; $display("FAIL single_ptr6 got sel=%0d want 6", sel); end
        tick();
        total++;
        if (ack !== 8'h40 || out_data !== 8'h66) begin
            bad++; $display("FAIL single_ch6 got ack=%h data=%h want 40/66", ack, out_data);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_all_req();
        logic [7:0] word;
        int         exp;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 8'hFF; ready = 1'b1;
        tick();
        total++;
        if (sel !== 3'd0) begin bad++; $display("FAIL allreq_first got sel=%0d want 0", sel); end
        for (int n = 0; n < 9; n++) begin
            exp  = n % 8;
            word = data[exp];
            tick();
            total++;
            if (ack !== (8'h01 << exp) || out_data !== word || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL allreq_grant%0d got ack=%h data=%h vld=%b want ack=%h data=%h vld=1",
                         n, ack, out_data, out_valid, 8'h01 << exp, word);
            end
            data[exp] = 8'($urandom);
            tick();
            total++;
            if (sel !== 3'((exp + 1) % 8) || out_valid !== 1'b0 || ack !== 8'h00) begin
                bad++;
                $display("FAIL allreq_next%0d got sel=%0d vld=%b ack=%h want %0d/0/00",
                         n, sel, out_valid, ack, (exp + 1) % 8);
            end
        end
    endtask

    // Entered with channel 1 selected (SELECT state) from test_all_req.
    task automatic test_backpressure();
        logic [7:0] word;
        word  = data[1];
        ready = 1'b0;
        tick();
        total++;
        if (ack !== 8'h02 || out_data !== word || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_first got ack=%h data=%h vld=%b want 02/%h/1", ack, out_data, out_valid, word);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (ack !== 8'h00 || out_data !== word || sel !== 3'd1 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d got ack=%h data=%h sel=%0d vld=%b want 00/%h/1/1",
                         c, ack, out_data, sel, out_valid, word);
            end
        end
        ready = 1'b1; req = 8'h00;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || ack !== 8'h00) begin
                bad++; $display("FAIL bp_release%0d got vld=%b ack=%h want 0/00", c, out_valid, ack);
            end
        end
    endtask

    // ptr starts at 2 from the backpressure release.
    task automatic test_wrap();
        data[6] = 8'h16; data[7] = 8'h17; data[0] = 8'h10; data[1] = 8'h11;
        req = 8'h40; ready = 1'b1;
        tick(); tick();
        total++;
        if (ack !== 8'h40 || out_data !== 8'h16) begin
            bad++; $display("FAIL wrap_ch6 got ack=%h data=%h want 40/16", ack, out_data);
        end
        req = 8'h81;
        tick();
        total++;
        if (sel !== 3'd7) begin bad++; $display("FAIL wrap_sel7 got sel=%0d want 7", sel); end
        tick();
        total++;
        if (ack !== 8'h80 || out_data !== 8'h17) begin
            bad++; $display("FAIL wrap_ch7 got ack=%h data=%h want 80/17", ack, out_data);
        end
        req = 8'h01;
        tick();
        total++;
        if (sel !== 3'd0) begin bad++; $display("FAIL wrap_sel0 got sel=%0d want 0", sel); end
        tick();
        total++;
        if (ack !== 8'h01 || out_data !== 8'h10) begin
            bad++; $display("FAIL wrap_ch0 got ack=%h data=%h want 01/10", ack, out_data);
        end
        req = 8'h00;
        tick();
        // ptr should now be 1: channel 1 wins over channel 0
        req = 8'h03;
        tick();
        total++;
        if (sel !== 3'd1) begin bad++; $display("FAIL wrap_ptr1 got sel=%0d want 1", sel); end
    endtask

    // Entered with channel 1 selected and req=03 from test_wrap.
    task automatic test_reset_in_hold();
        ready = 1'b0;
        tick();
        total++;
        if (ack !== 8'h02 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rsthold_pre got ack=%h vld=%b want 02/1", ack, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 8'h00;
        total++;
        if (out_valid !== 1'b0 || ack !== 8'h00 || sel !== 3'd0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL rsthold_rst got vld=%b ack=%h sel=%0d data=%h want 0/00/0/00",
                     out_valid, ack, sel, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || ack !== 8'h00) begin
            bad++; $display("FAIL rsthold_noack got vld=%b ack=%h want 0/00", out_valid, ack);
        end
        // ptr back to 0: channel 0 wins over channel 1
        req = 8'h03;
        tick();
        total++;
        if (sel !== 3'd0) begin bad++; $display("FAIL rsthold_ptr0 got sel=%0d want 0", sel); end
        tick();
        req = 8'h02; ready = 1'b1;
        tick();
        req = 8'h00;
    endtask

    task automatic test_random();
        rst = 1'b1; req = 8'h00; tick(); rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            total++;
            if (sel !== 3'(m_sel) || ack !== m_ack || out_valid !== m_valid || out_data !== m_data) begin
                bad++;
                $display("FAIL random_c%0d got sel=%0d ack=%h vld=%b data=%h want %0d/%h/%b/%h",
                         c, sel, ack, out_valid, out_data, m_sel, m_ack, m_valid, m_data);
            end
            for (int i = 0; i < 8; i++) begin
                if (ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    if (req[i]) data[i] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]  = 1'b1;
                    data[i] = 8'($urandom);
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) data[i] = 8'(8'h30 + i);
        rst = 1'b1; req = 8'h00; ready = 1'b0;
        m_phase = 0; m_sel = 0; m_ptr = 0; m_ack = 8'h00; m_valid = 1'b0; m_data = 8'h00;
        test_reset();
        test_single();
        test_all_req();
        test_backpressure();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
